// File: rtl/minilab1_2_if.sv
// FIFO bus: a producer/consumer pair of push/pop strobes, write data,
// show-ahead read data and the full/empty flags.
interface minilab1_2_if #(
    parameter int DATA_W = 8
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;

    modport master (
        output push,
        output pop,
        output din,
        input  dout,
        input  full,
        input  empty
    );

    modport slave (
        input  push,
        input  pop,
        input  din,
        output dout,
        output full,
        output empty
    );
endinterface

// File: rtl/minilab1_2.sv
// Matrix-vector multiply demo: a ROM holding an 8x8 matrix A and a vector B
// is streamed into nine FIFOs, then eight MACs compute C = A*B. The selected
// result row is shown on the seven-segment displays once the run completes.

// Synchronous FIFO with show-ahead output; push when full and pop when empty
// are dropped.
module minilab1_2_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input logic         clk,
    input logic         rst,
    minilab1_2_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.full  = (count == CNT_W'(DEPTH));
    assign bus.empty = (count == '0);
    assign bus.dout  = mem[rd_ptr];
    assign do_push   = bus.push && !bus.full;
    assign do_pop    = bus.pop && !bus.empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= bus.din;
    end
endmodule

module minilab1_2 #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ACC_W      = 24
) (
    input  logic       CLOCK_50,
    input  logic       CLOCK2_50,
    input  logic       CLOCK3_50,
    input  logic       CLOCK4_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);
    localparam int N        = FIFO_DEPTH;
    localparam int NUM_FIFO = 9;
    localparam int WORD_W   = DATA_W * N;
    localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        FILL   = 3'd2,
        EXEC   = 3'd3,
        FINISH = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              rst;
    logic [3:0]        addr;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  exec_cnt;
    logic [WORD_W-1:0] rom_q;

    logic [NUM_FIFO-1:0] push_vec;
    logic                pop_all;
    logic                mac_en;
    logic [DATA_W-1:0]   fill_din;
    logic [DATA_W-1:0]   fifo_dout [NUM_FIFO];
    logic [NUM_FIFO-1:0] fifo_empty;
    logic [NUM_FIFO-1:0] fifo_full;
    logic                all_nonempty;

    logic [ACC_W-1:0]  acc [8];
    logic [23:0]       disp_val;
    logic              unused_ok;

    assign rst          = ~KEY[0];
    assign all_nonempty = ~|fifo_empty;
    assign mac_en       = pop_all;
    assign unused_ok    = ^{CLOCK2_50, CLOCK3_50, CLOCK4_50, KEY[3:1], SW[9:3], fifo_full};

    // Words 0..7 are rows of A (element = 8*i+j+1), word 8 is B (element = j+1).
    function automatic logic [WORD_W-1:0] rom_word(input logic [3:0] a);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (a < 4'd8)
                w[j*DATA_W +: DATA_W] = DATA_W'(32'(a) * 8 + j + 1);
            else if (a == 4'd8)
                w[j*DATA_W +: DATA_W] = DATA_W'(j + 1);
        end
        return w;
    endfunction

    // Active-low segment pattern, bit 0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = READ;
            READ:   state_nxt = FILL;
            FILL: begin
                if (byte_cnt == CNT_W'(N - 1))
                    state_nxt = (addr == 4'd8) ? EXEC : READ;
            end
            EXEC: begin
                if (pop_all && exec_cnt == CNT_W'(N - 1))
                    state_nxt = FINISH;
            end
            FINISH: state_nxt = DONE;
            DONE:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: FIFO push select, shared write byte, and the joint pop.
    always_comb begin
        push_vec = '0;
        pop_all  = 1'b0;
        fill_din = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (byte_cnt == CNT_W'(j)) fill_din = rom_q[j*DATA_W +: DATA_W];
        end
        case (state)
            FILL: begin
                for (int unsigned k = 0; k < NUM_FIFO; k++)
                    push_vec[k] = (addr == 4'(k));
            end
            EXEC:    pop_all = all_nonempty;
            default: ;
        endcase
    end

    // Word address, byte index within the word, and pop counter.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            addr     <= '0;
            byte_cnt <= '0;
            exec_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    addr     <= '0;
                    byte_cnt <= '0;
                    exec_cnt <= '0;
                end
                FILL: begin
                    if (byte_cnt == CNT_W'(N - 1)) begin
                        byte_cnt <= '0;
                        addr     <= addr + 1'b1;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (pop_all) exec_cnt <= exec_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered ROM read, captured while the address is issued in READ.
    always_ff @(posedge CLOCK_50) begin
        if (rst)                rom_q <= '0;
        else if (state == READ) rom_q <= rom_word(addr);
    end

    // FIFOs 0..7 hold rows of A, FIFO 8 holds B.
    for (genvar k = 0; k < NUM_FIFO; k++) begin : g_fifo
        minilab1_2_if #(.DATA_W(DATA_W)) bus ();

        assign bus.push      = push_vec[k];
        assign bus.pop       = pop_all;
        assign bus.din       = fill_din;
        assign fifo_dout[k]  = bus.dout;
        assign fifo_empty[k] = bus.empty;
        assign fifo_full[k]  = bus.full;

        minilab1_2_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (N)
        ) u_fifo (
            .clk (CLOCK_50),
            .rst (rst),
            .bus (bus)
        );
    end

    // MAC array: each row accumulates A_i * B over the popped elements.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) acc[i] <= '0;
        end else if (mac_en) begin
            for (int unsigned i = 0; i < 8; i++)
                acc[i] <= acc[i] + ACC_W'(fifo_dout[i]) * ACC_W'(fifo_dout[8]);
        end
    end

    // Display the switch-selected accumulator only once the run is complete.
    always_comb begin
        disp_val = 24'(acc[SW[2:0]]);
        HEX0 = 7'h7F;
        HEX1 = 7'h7F;
        HEX2 = 7'h7F;
        HEX3 = 7'h7F;
        HEX4 = 7'h7F;
        HEX5 = 7'h7F;
        if (state == DONE) begin
            HEX0 = seg7(disp_val[3:0]);
            HEX1 = seg7(disp_val[7:4]);
            HEX2 = seg7(disp_val[11:8]);
            HEX3 = seg7(disp_val[15:12]);
            HEX4 = seg7(disp_val[19:16]);
            HEX5 = seg7(disp_val[23:20]);
        end
    end

    assign LEDR = {7'b0, state};
endmodule

// File: tb/tb_minilab1_2.sv
// Directed bench for minilab1_2: reset behaviour, 91-edge completion latency,
// result display sweep, reset during FILL and EXEC, and a standalone FIFO check.
module tb_minilab1_2;
    logic       CLOCK_50;
    logic       CLOCK2_50;
    logic       CLOCK3_50;
    logic       CLOCK4_50;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic       frst;

    int checks = 0;
    int errors = 0;

    minilab1_2 #(
        .DATA_W     (8),
        .FIFO_DEPTH (8),
        .ACC_W      (24)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .CLOCK2_50 (CLOCK2_50),
        .CLOCK3_50 (CLOCK3_50),
        .CLOCK4_50 (CLOCK4_50),
        .KEY       (KEY),
        .SW        (SW),
        .LEDR      (LEDR),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5)
    );

    minilab1_2_if #(.DATA_W(8)) fbus ();

    minilab1_2_fifo #(
        .DATA_W (8),
        .DEPTH  (8)
    ) u_fifo (
        .clk (CLOCK_50),
        .rst (frst),
        .bus (fbus)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Advance n rising edges, then settle on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [41:0] hex_of(input logic [23:0] v);
        return {seg(v[23:20]), seg(v[19:16]), seg(v[15:12]),
                seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
    endfunction

    logic [41:0] hex_all;
    assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    localparam logic [41:0] HEX_OFF = {6{7'h7F}};

    logic [23:0] c_exp [8];

    initial begin
        c_exp[0] = 24'h0000CC;
        c_exp[1] = 24'h0001EC;
        c_exp[2] = 24'h00030C;
        c_exp[3] = 24'h00042C;
        c_exp[4] = 24'h00054C;
        c_exp[5] = 24'h00066C;
        c_exp[6] = 24'h00078C;
        c_exp[7] = 24'h0008AC;

        CLOCK2_50 = 1'b0;
        CLOCK3_50 = 1'b0;
        CLOCK4_50 = 1'b0;
        KEY       = 4'hE;
        SW        = 10'd0;
        frst      = 1'b1;
        fbus.push = 1'b0;
        fbus.pop  = 1'b0;
        fbus.din  = 8'd0;

        // Reset held for five cycles.
        tick(5);
        check("rst_state", 48'(dut.state), 48'd0);
        check("rst_ledr", 48'(LEDR), 48'd0);
        check("rst_hex", 48'(hex_all), 48'(HEX_OFF));

        // Release and track the 91-edge run.
        KEY = 4'hF;
        tick(1);
        check("run_e1_read", 48'(dut.state), 48'd1);
        tick(1);
        check("run_e2_fill", 48'(dut.state), 48'd2);
        check("run_e2_hex_off", 48'(hex_all), 48'(HEX_OFF));
        tick(80);
        check("run_e82_exec", 48'(dut.state), 48'd3);
        tick(8);
        check("run_e90_finish", 48'(dut.state), 48'd4);
        tick(1);
        check("run_e91_done", 48'(dut.state), 48'd5);
        check("run_ledr_done", 48'(LEDR), 48'd5);
        tick(100);
        check("done_hold_state", 48'(dut.state), 48'd5);
        check("done_acc0_frozen", 48'(dut.acc[0]), 48'h0000CC);

        // Sweep the displayed row without any clock edge between changes.
        for (int i = 0; i < 8; i++) begin
            SW = 10'(i);
            #1;
            check($sformatf("sweep_row%0d", i), 48'(hex_all), 48'(hex_of(c_exp[i])));
        end
        SW = 10'h3F8;
        #1;
        check("sweep_upper_sw_ignored", 48'(hex_all), 48'(hex_of(c_exp[0])));
        SW = 10'd0;

        // Reset while filling word 4.
        KEY = 4'hE;
        tick(1);
        KEY = 4'hF;
        tick(40);
        check("fill_state", 48'(dut.state), 48'd2);
        check("fill_addr", 48'(dut.addr), 48'd4);
        KEY = 4'hE;
        tick(1);
        check("fill_rst_state", 48'(dut.state), 48'd0);
        check("fill_rst_addr", 48'(dut.addr), 48'd0);
        check("fill_rst_empty", 48'(dut.fifo_empty), 48'h1FF);
        check("fill_rst_ledr", 48'(LEDR), 48'd0);
        check("fill_rst_hex", 48'(hex_all), 48'(HEX_OFF));
        KEY = 4'hF;
        tick(90);
        check("fill_rerun_e90", 48'(dut.state), 48'd4);
        tick(1);
        check("fill_rerun_e91", 48'(dut.state), 48'd5);
        SW = 10'd0;
        #1;
        check("fill_rerun_c0", 48'(hex_all), 48'(hex_of(c_exp[0])));
        SW = 10'd7;
        #1;
        check("fill_rerun_c7", 48'(hex_all), 48'(hex_of(c_exp[7])));
        SW = 10'd0;

        // Reset mid-EXEC.
        KEY = 4'hE;
        tick(1);
        KEY = 4'hF;
        tick(85);
        check("exec_state", 48'(dut.state), 48'd3);
        KEY = 4'hE;
        tick(1);
        check("exec_rst_state", 48'(dut.state), 48'd0);
        check("exec_rst_acc0", 48'(dut.acc[0]), 48'd0);
        check("exec_rst_acc7", 48'(dut.acc[7]), 48'd0);
        check("exec_rst_empty", 48'(dut.fifo_empty), 48'h1FF);
        KEY = 4'hF;
        tick(91);
        check("exec_rerun_done", 48'(dut.state), 48'd5);
        check("exec_rerun_acc0", 48'(dut.acc[0]), 48'd204);
        #1;
        check("exec_rerun_hex0", 48'(hex_all), 48'(hex_of(c_exp[0])));

        // Standalone FIFO: overfill and overdrain.
        tick(1);
        frst = 1'b0;
        check("fifo_rst_empty", 48'(fbus.empty), 48'd1);
        for (int k = 0; k < 9; k++) begin
            fbus.din  = 8'(8'h10 + k);
            fbus.push = 1'b1;
            tick(1);
            if (k == 7) check("fifo_full_at_8", 48'(fbus.full), 48'd1);
        end
        fbus.push = 1'b0;
        check("fifo_full_after_9", 48'(fbus.full), 48'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fifo_pop%0d", k), 48'(fbus.dout), 48'(8'h10 + k));
            fbus.pop = 1'b1;
            tick(1);
            fbus.pop = 1'b0;
        end
        check("fifo_empty_after_8", 48'(fbus.empty), 48'd1);
        fbus.pop = 1'b1;
        tick(1);
        fbus.pop = 1'b0;
        check("fifo_empty_after_9", 48'(fbus.empty), 48'd1);
        check("fifo_not_full_after_9", 48'(fbus.full), 48'd0);
        fbus.din  = 8'h55;
        fbus.push = 1'b1;
        tick(1);
        fbus.push = 1'b0;
        check("fifo_push_after_drain", 48'(fbus.dout), 48'h55);
        check("fifo_nonempty_after_push", 48'(fbus.empty), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/minilab1_2.md
MINILAB1_2 -- requirements
Module: minilab1_2

Interface
REQ-001 Parameters, one per line: DATA_W, 8, matrix/vector element width (unsigned).
REQ-002 FIFO_DEPTH, 8, entries per FIFO; equals vector length N.
REQ-003 ACC_W, 24, MAC accumulator width.
REQ-004 CLOCK_50  in  1  sole functional clock; all logic on rising edge.
REQ-005 KEY  in  4  KEY[0] is the reset source; internal rst = ~KEY[0]; KEY[3:1] unused.
REQ-006 Reset SHALL be synchronous and active-high on internal rst, sampled on CLOCK_50 rising edge only.
REQ-007 CLOCK2_50, CLOCK3_50, CLOCK4_50  in  1 each  unused; no logic attached.
REQ-008 SW  in  10  SW[2:0] selects displayed result row; SW[9:3] unused.
REQ-009 LEDR  out  10  LEDR[2:0] = state; LEDR[9:3] = 0.
REQ-010 HEX0..HEX5  out  7 each  active-low seven-segment digits, HEX0 least significant nibble.
REQ-011 Internal register state[2:0] SHALL exist under exactly that name (hierarchically probed).

Function
REQ-012 Internal ROM SHALL hold 9 words of 64 bits, 1-cycle registered read; byte j of word i (i=0..7) = A[i][j] = 8*i+j+1; byte j of word 8 = B[j] = j+1.
REQ-013 Nine FIFOs (8 A-row FIFOs, 1 B FIFO), DATA_W wide, FIFO_DEPTH deep, with full/empty flags; push when full and pop when empty SHALL be ignored.
REQ-014 Eight MAC units: on enable, acc_i <= acc_i + A_i*B (8x8 unsigned product, zero-extended, ACC_W wrap-around).
REQ-015 State encoding: 0 IDLE, 1 READ, 2 FILL, 3 EXEC, 4 FINISH, 5 DONE.
REQ-016 IDLE -> READ unconditionally after one cycle; word address cleared.
REQ-017 READ: issue ROM address (one cycle) -> FILL.
REQ-018 FILL: push bytes 0..7 of the registered word, one per cycle, into FIFO[addr] (addr 8 = B FIFO); after 8th push, addr++; addr < 9 -> READ, else -> EXEC.
REQ-019 EXEC: while all nine FIFOs non-empty, pop all nine simultaneously and enable all MACs in the same cycle; after the 8th pop -> FINISH.
REQ-020 FINISH: one cycle for final accumulator update -> DONE.
REQ-021 DONE: hold state 5 indefinitely, accumulators frozen, until reset.
REQ-022 DONE SHALL be entered exactly 91 rising edges after the first edge with rst=0.
REQ-023 Expected results: C[i] = 288*i + 204 (C0 = 0x0000CC, C7 = 0x0008AC).
REQ-024 In DONE, HEX5..HEX0 show hex digits of acc[SW[2:0]] combinationally (SW change visible same cycle); outside DONE all segments off (7'h7F).

Reset
REQ-025 rst=1 SHALL at the next edge set state=0, addr=0, clear all FIFO pointers/counts, all accumulators=0, ROM output register=0.
REQ-026 Reset SHALL take priority over every transition, including mid-FILL and mid-EXEC; no partial data survives.
REQ-027 Outputs during/after reset: LEDR=0, HEX0..HEX5=7'h7F.

Verification
REQ-028 Hold KEY[0]=0 for 5 cycles -> state=0, LEDR=0, all HEX=7'h7F; release -> state=5 at edge 91, then stays 5 for 100+ cycles.
REQ-029 In DONE sweep SW[2:0]=0..7 -> displayed value 288*i+204 each (SW=0 -> 0000CC, SW=7 -> 0008AC).
REQ-030 Assert KEY[0]=0 during FILL (state 2, addr 4) -> state 0 next edge; release -> identical results and 91-cycle latency.
REQ-031 Assert reset during EXEC -> accumulators 0, FIFOs empty; rerun gives C0=204.
REQ-032 FIFO unit check: 9 pushes into 8-deep FIFO -> full set, 9th ignored; 9 pops -> 8 values in order, empty set, 9th pop ignored.
